// File: rtl/reset_seq_if.sv
// Memory-init request/done handshake between the reset
// sequencer (master) and the memory controller (slave).
interface reset_seq_if;
   logic mem_init_req;
   logic mem_init_done;

   modport master (
      output mem_init_req,
      input  mem_init_done
   );

   modport slave (
      input  mem_init_req,
      output mem_init_done
   );
endinterface

// File: rtl/reset_seq.sv
// Power-up reset sequencer: sync release, settle, memory
// init with timeout/retry, then CPU reset release.
module reset_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1000,
   parameter int CPU_DLY     = 8,
   parameter int RETRIES     = 2
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        soft_rst_req,
   reset_seq_if.master mem_if,
   output logic        mem_rst,
   output logic        cpu_rst,
   output logic        ready,
   output logic        timeout_err,
   output logic        fail
);

   typedef enum logic [2:0] {
      S_HOLD,
      S_SETTLE,
      S_INIT,
      S_CPU_WAIT,
      S_RUN,
      S_FAIL
   } state_t;

   localparam logic [15:0] L_SET = 16'(SETTLE_CYC - 1);
   localparam logic [15:0] L_TO  = 16'(TIMEOUT_CYC - 1);
   localparam logic [15:0] L_CPU = 16'(CPU_DLY - 1);
   localparam logic [2:0]  L_RET = 3'(RETRIES);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rel;

   state_t      r_state;
   state_t      w_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [2:0]  r_retry;
   logic [2:0]  w_retry_nxt;
   logic        w_to_set;

   logic w_mem_rst;
   logic w_req;
   logic w_cpu_rst;
   logic w_ready;

   logic r_mem_rst;
   logic r_req;
   logic r_cpu_rst;
   logic r_ready;
   logic r_te;
   logic r_fail;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign w_rel = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state <= S_HOLD;
      end else begin
         r_state <= w_nxt;
      end
   end

   always_comb begin
      w_nxt       = r_state;
      w_cnt_nxt   = r_cnt + 16'd1;
      w_retry_nxt = r_retry;
      w_to_set    = 1'b0;
      if (soft_rst_req && (r_state != S_HOLD)) begin
         w_nxt       = S_SETTLE;
         w_cnt_nxt   = '0;
         w_retry_nxt = '0;
      end else begin
         unique case (r_state)
            S_HOLD: begin
               w_cnt_nxt = '0;
               if (w_rel) begin
                  w_nxt = S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt == L_SET) begin
                  w_nxt     = S_INIT;
                  w_cnt_nxt = '0;
               end
            end
            S_INIT: begin
               // done beats a coincident timeout
               if (mem_if.mem_init_done) begin
                  w_nxt     = S_CPU_WAIT;
                  w_cnt_nxt = '0;
               end else if (r_cnt == L_TO) begin
                  w_to_set  = 1'b1;
                  w_cnt_nxt = '0;
                  if (r_retry < L_RET) begin
                     w_retry_nxt = r_retry + 3'd1;
                     w_nxt       = S_SETTLE;
                  end else begin
                     w_nxt = S_FAIL;
                  end
               end
            end
            S_CPU_WAIT: begin
               if (r_cnt == L_CPU) begin
                  w_nxt     = S_RUN;
                  w_cnt_nxt = '0;
               end
            end
            S_RUN: begin
               w_cnt_nxt = '0;
            end
            S_FAIL: begin
               w_cnt_nxt = '0;
            end
            default: begin
               w_nxt     = S_HOLD;
               w_cnt_nxt = '0;
            end
         endcase
      end
   end

   // outputs decode the next state so they register with it
   always_comb begin
      w_mem_rst = 1'b1;
      w_req     = 1'b0;
      w_cpu_rst = 1'b1;
      w_ready   = 1'b0;
      unique case (1'b1)
         (w_nxt == S_INIT): begin
            w_mem_rst = 1'b0;
            w_req     = 1'b1;
         end
         (w_nxt == S_CPU_WAIT): begin
            w_mem_rst = 1'b0;
         end
         (w_nxt == S_RUN): begin
            w_mem_rst = 1'b0;
            w_cpu_rst = 1'b0;
            w_ready   = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_cnt     <= '0;
         r_retry   <= '0;
         r_mem_rst <= 1'b1;
         r_req     <= 1'b0;
         r_cpu_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_te      <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_retry   <= w_retry_nxt;
         r_mem_rst <= w_mem_rst;
         r_req     <= w_req;
         r_cpu_rst <= w_cpu_rst;
         r_ready   <= w_ready;
         r_te      <= r_te | w_to_set;
         r_fail    <= (w_nxt == S_FAIL);
      end
   end

   assign mem_rst             = r_mem_rst;
   assign mem_if.mem_init_req = r_req;
   assign cpu_rst             = r_cpu_rst;
   assign ready               = r_ready;
   assign timeout_err         = r_te;
   assign fail                = r_fail;

   a_cpu_run : assert property (
      @(posedge clk) disable iff (!rst_)
      !r_cpu_rst |-> (r_state == S_RUN));

   a_req_mem : assert property (
      @(posedge clk) disable iff (!rst_)
      r_req |-> !r_mem_rst);

   a_rdy_cpu : assert property (
      @(posedge clk) disable iff (!rst_)
      r_ready |-> !r_cpu_rst);

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: stimulus queues expected
// output-vector changes, a negedge monitor pops and compares.
module tb_reset_seq;

   // {mem_rst, mem_init_req, cpu_rst, ready, timeout_err, fail}
   localparam logic [5:0] V_HOLD = 6'b101000;
   localparam logic [5:0] V_INIT = 6'b011000;
   localparam logic [5:0] V_CW   = 6'b001000;
   localparam logic [5:0] V_RUN  = 6'b000100;
   localparam logic [5:0] V_FAIL = 6'b101011;
   localparam logic [5:0] TE     = 6'b000010;

   typedef struct {
      int         edge_n;
      logic [5:0] vec;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_;
   logic soft_rst_req;
   logic mem_rst;
   logic cpu_rst;
   logic ready;
   logic timeout_err;
   logic fail;

   int   edge_cnt = 0;
   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];
   logic [5:0] prev = V_HOLD;
   logic [5:0] cur;

   reset_seq_if u_if ();

   reset_seq #(
      .SYNC_STAGES(2),
      .SETTLE_CYC (8),
      .TIMEOUT_CYC(20),
      .CPU_DLY    (4),
      .RETRIES    (2)
   ) dut (
      .clk         (clk),
      .rst_        (rst_),
      .soft_rst_req(soft_rst_req),
      .mem_if      (u_if.master),
      .mem_rst     (mem_rst),
      .cpu_rst     (cpu_rst),
      .ready       (ready),
      .timeout_err (timeout_err),
      .fail        (fail)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [5:0] get_vec();
      return {mem_rst, u_if.mem_init_req, cpu_rst,
              ready, timeout_err, fail};
   endfunction

   task automatic ev(input int e, input logic [5:0] v,
                     input string n);
      exp_t x;
      x.edge_n = e;
      x.vec    = v;
      x.name   = n;
      q.push_back(x);
   endtask

   task automatic chk(input string n, input logic [5:0] got,
                      input logic [5:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%b want=%b", n, got, want);
      end
   endtask

   task automatic goto(input int n);
      while (edge_cnt < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      cur = get_vec();
      if (cur != prev) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change edge=%0d got=%b",
                     edge_cnt, cur);
         end else begin
            exp_t x;
            x = q.pop_front();
            if (cur !== x.vec || edge_cnt != x.edge_n) begin
               failures++;
               $display("FAIL %s got edge=%0d vec=%b want edge=%0d vec=%b",
                        x.name, edge_cnt, cur, x.edge_n, x.vec);
            end
         end
      end
      prev = cur;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog edge=%0d pending=%0d",
               edge_cnt, q.size());
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      int r;
      int b;
      rst_              = 1'b1;
      soft_rst_req      = 1'b0;
      u_if.mem_init_done = 1'b0;
      #1 rst_ = 1'b0;
      #2;
      chk("reset_vec", get_vec(), V_HOLD);

      // clean release, done on 3rd INIT cycle
      goto(2);
      #2;
      r = edge_cnt;
      ev(r + 11, V_INIT, "s1_init");
      ev(r + 14, V_CW,   "s1_cw");
      ev(r + 18, V_RUN,  "s1_run");
      rst_ = 1'b1;
      goto(r + 13);
      u_if.mem_init_done = 1'b1;
      goto(r + 14);
      u_if.mem_init_done = 1'b0;
      goto(r + 20);
      chk("s1_final", get_vec(), V_RUN);

      // soft reset from RUN
      goto(r + 22);
      b = edge_cnt;
      ev(b + 1,  V_HOLD, "s2_soft");
      ev(b + 9,  V_INIT, "s2_init");
      ev(b + 12, V_CW,   "s2_cw");
      ev(b + 16, V_RUN,  "s2_run");
      soft_rst_req = 1'b1;
      goto(b + 1);
      soft_rst_req = 1'b0;
      goto(b + 11);
      u_if.mem_init_done = 1'b1;
      goto(b + 12);
      u_if.mem_init_done = 1'b0;
      goto(b + 18);
      chk("s2_final", get_vec(), V_RUN);

      // short async reset pulse mid-INIT
      b = edge_cnt;
      ev(b + 1,  V_HOLD, "s3_soft");
      ev(b + 9,  V_INIT, "s3_init");
      ev(b + 10, V_HOLD, "s3_async");
      soft_rst_req = 1'b1;
      goto(b + 1);
      soft_rst_req = 1'b0;
      goto(b + 10);
      #1 rst_ = 1'b0;
      #1 rst_ = 1'b1;
      #1;
      chk("s3_pulse", get_vec(), V_HOLD);
      r = edge_cnt;
      ev(r + 11, V_INIT, "s3_init2");
      ev(r + 14, V_CW,   "s3_cw");
      ev(r + 18, V_RUN,  "s3_run");
      goto(r + 13);
      u_if.mem_init_done = 1'b1;
      goto(r + 14);
      u_if.mem_init_done = 1'b0;
      goto(r + 20);
      chk("s3_final", get_vec(), V_RUN);

      // done exactly on the last INIT cycle
      b = edge_cnt;
      ev(b + 1,  V_HOLD, "s5_soft");
      ev(b + 9,  V_INIT, "s5_init");
      ev(b + 29, V_CW,   "s5_cw_edge");
      ev(b + 33, V_RUN,  "s5_run");
      soft_rst_req = 1'b1;
      goto(b + 1);
      soft_rst_req = 1'b0;
      goto(b + 28);
      u_if.mem_init_done = 1'b1;
      goto(b + 29);
      u_if.mem_init_done = 1'b0;
      goto(b + 35);
      chk("s5_final", get_vec(), V_RUN);

      // timeout, then done on 5th cycle of retry
      b = edge_cnt;
      ev(b + 1,  V_HOLD,      "s4_soft");
      ev(b + 9,  V_INIT,      "s4_init1");
      ev(b + 29, V_HOLD | TE, "s4_to");
      ev(b + 37, V_INIT | TE, "s4_init2");
      ev(b + 42, V_CW | TE,   "s4_cw");
      ev(b + 46, V_RUN | TE,  "s4_run");
      soft_rst_req = 1'b1;
      goto(b + 1);
      soft_rst_req = 1'b0;
      goto(b + 41);
      u_if.mem_init_done = 1'b1;
      goto(b + 42);
      u_if.mem_init_done = 1'b0;
      goto(b + 48);
      chk("s4_final", get_vec(), V_RUN | TE);

      // full reset, then no done ever
      b = edge_cnt;
      ev(b, V_HOLD, "s6_rst");
      #1 rst_ = 1'b0;
      goto(b + 1);
      #1;
      chk("s6_rst_hold", get_vec(), V_HOLD);
      rst_ = 1'b1;
      r = edge_cnt;
      ev(r + 11, V_INIT,      "s6_init1");
      ev(r + 31, V_HOLD | TE, "s6_to1");
      ev(r + 39, V_INIT | TE, "s6_init2");
      ev(r + 59, V_HOLD | TE, "s6_to2");
      ev(r + 67, V_INIT | TE, "s6_init3");
      ev(r + 87, V_FAIL,      "s6_fail");
      goto(r + 100);
      chk("s6_final", get_vec(), V_FAIL);

      // soft from FAIL, second soft restarts settle
      b = edge_cnt;
      ev(b + 1,  V_HOLD | TE, "s7_soft");
      ev(b + 13, V_INIT | TE, "s7_init");
      ev(b + 16, V_CW | TE,   "s7_cw");
      ev(b + 20, V_RUN | TE,  "s7_run");
      soft_rst_req = 1'b1;
      goto(b + 1);
      soft_rst_req = 1'b0;
      goto(b + 4);
      soft_rst_req = 1'b1;
      goto(b + 5);
      soft_rst_req = 1'b0;
      goto(b + 15);
      u_if.mem_init_done = 1'b1;
      goto(b + 16);
      u_if.mem_init_done = 1'b0;
      goto(b + 24);
      chk("s7_final", get_vec(), V_RUN | TE);

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL pending_events got=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
